// File: rtl/peak_scan_ctrl.sv
// Round-robin peak-magnitude scanner: one channel per window through a shared
// select -> abs -> peak-hold pipeline, result offered over valid/ready.
module peak_scan_ctrl #(
  parameter int INPUT_WIDTH = 16,
  parameter int NUM_CH      = 4,
  parameter int CH_W        = 2,
  parameter int WIN_W       = 24
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          enable_i,
  input  logic [WIN_W-1:0]              win_len_i,
  input  logic                          nd_i,
  input  logic [NUM_CH*INPUT_WIDTH-1:0] data_in_i,
  output logic                          res_valid_o,
  input  logic                          res_ready_i,
  output logic [CH_W-1:0]               res_ch_o,
  output logic [INPUT_WIDTH-1:0]        res_max_o,
  output logic                          busy_o,
  output logic [CH_W-1:0]               cur_ch_o
);
  localparam logic [INPUT_WIDTH-1:0] MOST_NEG = {1'b1, {(INPUT_WIDTH-1){1'b0}}};
  localparam logic [INPUT_WIDTH-1:0] MAX_POS  = {1'b0, {(INPUT_WIDTH-1){1'b1}}};

  typedef enum logic [2:0] {IDLE, ARM, MEASURE, DRAIN, REPORT} state_t;

  state_t                              state_q, state_d;
  logic [CH_W-1:0]                     cur_ch_q, cur_ch_d;
  logic [WIN_W-1:0]                    len_q, cnt_q, cnt_inc;
  logic                                drain_q;
  logic [INPUT_WIDTH-1:0]              s1_q, abs_q, abs_d, peak_q;
  logic [1:0]                          vld_pipe_q;
  logic                                smp_take;
  logic [NUM_CH-1:0][INPUT_WIDTH-1:0]  din;

  assign din     = data_in_i;
  assign cnt_inc = cnt_q + 1'b1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cur_ch_q <= '0;
    end else begin
      state_q  <= state_d;
      cur_ch_q <= cur_ch_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cur_ch_d = cur_ch_q;
    smp_take = 1'b0;
    case (state_q)
      IDLE: begin
        cur_ch_d = '0;
        if (enable_i) state_d = ARM;
      end
      ARM: state_d = MEASURE;
      MEASURE: begin
        if (nd_i) begin
          smp_take = 1'b1;
          if (cnt_inc == len_q) state_d = DRAIN;
        end
      end
      DRAIN: if (drain_q) state_d = REPORT;
      REPORT: begin
        if (res_ready_i) begin
          if (enable_i) begin
            state_d  = ARM;
            cur_ch_d = (cur_ch_q == CH_W'(NUM_CH-1)) ? '0 : cur_ch_q + 1'b1;
          end else begin
            state_d  = IDLE;
            cur_ch_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Most-negative input has no positive twin; clamp it to full-scale.
  always_comb begin
    abs_d = s1_q;
    if (s1_q[INPUT_WIDTH-1])
      abs_d = (s1_q == MOST_NEG) ? MAX_POS : (~s1_q + 1'b1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      len_q      <= '0;
      cnt_q      <= '0;
      drain_q    <= 1'b0;
      s1_q       <= '0;
      abs_q      <= '0;
      peak_q     <= '0;
      vld_pipe_q <= '0;
    end else begin
      drain_q <= (state_q == DRAIN) ? ~drain_q : 1'b0;
      if (state_q == ARM) begin
        len_q      <= (win_len_i == '0) ? WIN_W'(1) : win_len_i;
        cnt_q      <= '0;
        peak_q     <= '0;
        vld_pipe_q <= '0;
      end else begin
        vld_pipe_q <= {vld_pipe_q[0], smp_take};
        if (smp_take) begin
          s1_q  <= din[cur_ch_q];
          cnt_q <= cnt_inc;
        end
        if (vld_pipe_q[0]) abs_q <= abs_d;
        if (vld_pipe_q[1] && (abs_q > peak_q)) peak_q <= abs_q;
      end
    end
  end

  assign res_valid_o = (state_q == REPORT);
  assign res_ch_o    = cur_ch_q;
  assign res_max_o   = peak_q;
  assign busy_o      = (state_q != IDLE);
  assign cur_ch_o    = cur_ch_q;
endmodule

// File: tb/tb_peak_scan_ctrl.sv
// Directed bench for peak_scan_ctrl: windows, saturation, round-robin,
// backpressure, short windows, enable drop and reset during report.
module tb_peak_scan_ctrl;
  localparam int IW = 16, NCH = 4, CW = 2, WW = 24;

  logic              clk = 1'b0;
  logic              rst, enable, nd, res_ready;
  logic [WW-1:0]     win_len;
  logic [NCH*IW-1:0] data_in;
  logic              res_valid, busy;
  logic [CW-1:0]     res_ch, cur_ch;
  logic [IW-1:0]     res_max;
  int checks = 0, fails = 0;

  peak_scan_ctrl #(.INPUT_WIDTH(IW), .NUM_CH(NCH), .CH_W(CW), .WIN_W(WW)) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .win_len_i(win_len), .nd_i(nd),
    .data_in_i(data_in), .res_valid_o(res_valid), .res_ready_i(res_ready),
    .res_ch_o(res_ch), .res_max_o(res_max), .busy_o(busy), .cur_ch_o(cur_ch));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_data(input logic [IW-1:0] c0, c1, c2, c3);
    data_in = {c3, c2, c1, c0};
  endtask

  // Called in the cycle after the last window nd; counts edges until res_valid.
  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!res_valid && cyc < 50) begin tick(); cyc++; end
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); rst = 1'b0;
    checks++; if (res_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", res_valid); end
    checks++; if (res_ch !== 2'd0) begin fails++; $display("FAIL reset_ch got %0d exp 0", res_ch); end
    checks++; if (res_max !== 16'h0) begin fails++; $display("FAIL reset_max got %h exp 0000", res_max); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (cur_ch !== 2'd0) begin fails++; $display("FAIL reset_cur_ch got %0d exp 0", cur_ch); end
  endtask

  task automatic test_single();
    logic [IW-1:0] smp [4];
    int cyc;
    smp[0] = 16'h0010; smp[1] = 16'hFF00; smp[2] = 16'h0123; smp[3] = 16'h0005;
    win_len = 24'd4; res_ready = 1'b1; enable = 1'b1;
    tick();
    checks++; if (busy !== 1'b1) begin fails++; $display("FAIL single_busy_arm got %b exp 1", busy); end
    tick();
    for (int i = 0; i < 4; i++) begin
      set_data(smp[i], 16'h7000, 16'h7000, 16'h7000); nd = 1'b1; tick();
    end
    nd = 1'b0;
    checks++; if (res_valid !== 1'b0) begin fails++; $display("FAIL single_drain1 got %b exp 0", res_valid); end
    tick();
    checks++; if (res_valid !== 1'b0) begin fails++; $display("FAIL single_drain2 got %b exp 0", res_valid); end
    tick();
    checks++; if (res_valid !== 1'b1) begin fails++; $display("FAIL single_valid got %b exp 1", res_valid); end
    checks++; if (res_ch !== 2'd0) begin fails++; $display("FAIL single_ch got %0d exp 0", res_ch); end
    // abs(0xFF00)=0x0100 is below 0x0123, so the positive sample is the peak.
    checks++; if (res_max !== 16'h0123) begin fails++; $display("FAIL single_max got %h exp 0123", res_max); end
    tick();
    checks++; if (res_valid !== 1'b0 || cur_ch !== 2'd1) begin fails++; $display("FAIL single_next got v=%b ch=%0d exp v=0 ch=1", res_valid, cur_ch); end
  endtask

  task automatic test_saturation_rr();
    logic [CW-1:0] exp_ch [3];
    logic [IW-1:0] exp_mx [3];
    int cyc;
    exp_ch[0] = 2'd2; exp_ch[1] = 2'd3; exp_ch[2] = 2'd0;
    exp_mx[0] = 16'h0222; exp_mx[1] = 16'h0223; exp_mx[2] = 16'h0011;
    win_len = 24'd2;
    tick();
    set_data(16'h0011, 16'h8000, 16'h0222, 16'hFDDD); nd = 1'b1; tick();
    set_data(16'h0011, 16'hFFF0, 16'h0222, 16'hFDDD); tick();
    nd = 1'b0; wait_valid(cyc);
    checks++; if (cyc !== 2) begin fails++; $display("FAIL sat_latency got %0d exp 2", cyc); end
    checks++; if (res_ch !== 2'd1) begin fails++; $display("FAIL sat_ch got %0d exp 1", res_ch); end
    checks++; if (res_max !== 16'h7FFF) begin fails++; $display("FAIL sat_max got %h exp 7fff", res_max); end
    tick();
    for (int k = 0; k < 3; k++) begin
      tick();
      nd = 1'b1; tick(); tick(); nd = 1'b0;
      wait_valid(cyc);
      checks++; if (res_valid !== 1'b1) begin fails++; $display("FAIL rr_valid[%0d] got %b exp 1", k, res_valid); end
      checks++; if (res_ch !== exp_ch[k]) begin fails++; $display("FAIL rr_ch[%0d] got %0d exp %0d", k, res_ch, exp_ch[k]); end
      checks++; if (res_max !== exp_mx[k]) begin fails++; $display("FAIL rr_max[%0d] got %h exp %h", k, res_max, exp_mx[k]); end
      tick();
    end
    checks++; if (cur_ch !== 2'd1) begin fails++; $display("FAIL rr_wrap got %0d exp 1", cur_ch); end
  endtask

  task automatic test_backpressure();
    int cyc;
    res_ready = 1'b0;
    set_data(16'h0011, 16'h0050, 16'h0030, 16'h0033);
    tick();
    nd = 1'b1; tick(); tick(); nd = 1'b0;
    wait_valid(cyc);
    set_data(16'h7000, 16'h7000, 16'h7000, 16'h7000); nd = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++; if (res_valid !== 1'b1 || res_ch !== 2'd1 || res_max !== 16'h0050 || cur_ch !== 2'd1)
        begin fails++; $display("FAIL bp_hold[%0d] got v=%b ch=%0d max=%h cur=%0d exp v=1 ch=1 max=0050 cur=1", i, res_valid, res_ch, res_max, cur_ch); end
    end
    nd = 1'b0; res_ready = 1'b1;
    set_data(16'h0011, 16'h0050, 16'h0030, 16'h0033);
    tick();
    checks++; if (res_valid !== 1'b0 || cur_ch !== 2'd2) begin fails++; $display("FAIL bp_release got v=%b ch=%0d exp v=0 ch=2", res_valid, cur_ch); end
    tick();
    nd = 1'b1; tick();
    nd = 1'b0;
    checks++; if (res_valid !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL bp_no_stale got v=%b busy=%b exp v=0 busy=1", res_valid, busy); end
    nd = 1'b1; tick(); nd = 1'b0;
    wait_valid(cyc);
    checks++; if (cyc !== 2 || res_max !== 16'h0030) begin fails++; $display("FAIL bp_next got cyc=%0d max=%h exp cyc=2 max=0030", cyc, res_max); end
  endtask

  task automatic test_winlen0_sparse();
    int cyc;
    win_len = 24'd0;
    set_data(16'h0011, 16'h0050, 16'h0030, 16'h0044);
    tick(); tick();
    nd = 1'b1; tick(); nd = 1'b0;
    tick(); tick();
    set_data(16'h0011, 16'h0050, 16'h0030, 16'h7777); nd = 1'b1;
    checks++; if (res_valid !== 1'b1 || res_ch !== 2'd3 || res_max !== 16'h0044)
      begin fails++; $display("FAIL len0_report got v=%b ch=%0d max=%h exp v=1 ch=3 max=0044", res_valid, res_ch, res_max); end
    tick(); nd = 1'b0;
    set_data(16'h0066, 16'hFF80, 16'h0030, 16'h0044);
    tick();
    tick(); tick();
    win_len = 24'd8;
    nd = 1'b1; tick(); nd = 1'b0;
    wait_valid(cyc);
    checks++; if (cyc !== 2 || res_ch !== 2'd0 || res_max !== 16'h0066)
      begin fails++; $display("FAIL len_change_late got cyc=%0d ch=%0d max=%h exp cyc=2 ch=0 max=0066", cyc, res_ch, res_max); end
    tick();
    tick();
    for (int i = 0; i < 7; i++) begin
      set_data(16'h0066, (i == 4) ? 16'h0100 : 16'hFF80, 16'h0030, 16'h0044);
      nd = 1'b1; tick(); nd = 1'b0; tick();
    end
    tick(); tick();
    checks++; if (res_valid !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL len8_early got v=%b busy=%b exp v=0 busy=1", res_valid, busy); end
    set_data(16'h0066, 16'hFF80, 16'h0030, 16'h0044);
    nd = 1'b1; tick(); nd = 1'b0;
    wait_valid(cyc);
    checks++; if (cyc !== 2 || res_ch !== 2'd1 || res_max !== 16'h0100)
      begin fails++; $display("FAIL len8_report got cyc=%0d ch=%0d max=%h exp cyc=2 ch=1 max=0100", cyc, res_ch, res_max); end
  endtask

  task automatic test_enable_drop();
    int cyc;
    win_len = 24'd3;
    tick(); tick();
    set_data(16'h0066, 16'h0050, 16'h0123, 16'h0044);
    nd = 1'b1; tick();
    enable = 1'b0;
    set_data(16'h0066, 16'h0050, 16'h0005, 16'h0044);
    tick(); tick(); nd = 1'b0;
    wait_valid(cyc);
    checks++; if (res_valid !== 1'b1 || res_ch !== 2'd2 || res_max !== 16'h0123)
      begin fails++; $display("FAIL endrop_report got v=%b ch=%0d max=%h exp v=1 ch=2 max=0123", res_valid, res_ch, res_max); end
    tick();
    checks++; if (res_valid !== 1'b0 || busy !== 1'b0 || cur_ch !== 2'd0)
      begin fails++; $display("FAIL endrop_idle got v=%b busy=%b cur=%0d exp v=0 busy=0 cur=0", res_valid, busy, cur_ch); end
    tick(); tick();
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL endrop_stay got busy=%b exp 0", busy); end
  endtask

  task automatic test_rst_in_report();
    int cyc;
    win_len = 24'd1; res_ready = 1'b0; enable = 1'b1;
    set_data(16'h0777, 16'h0050, 16'h0030, 16'h0044);
    tick(); tick();
    nd = 1'b1; tick(); nd = 1'b0;
    wait_valid(cyc);
    checks++; if (res_valid !== 1'b1 || res_max !== 16'h0777) begin fails++; $display("FAIL rst_pre got v=%b max=%h exp v=1 max=0777", res_valid, res_max); end
    rst = 1'b1; res_ready = 1'b1;
    tick(); rst = 1'b0;
    checks++; if (res_valid !== 1'b0 || res_ch !== 2'd0 || res_max !== 16'h0 || busy !== 1'b0 || cur_ch !== 2'd0)
      begin fails++; $display("FAIL rst_clear got v=%b ch=%0d max=%h busy=%b cur=%0d exp all 0", res_valid, res_ch, res_max, busy, cur_ch); end
    tick();
    checks++; if (busy !== 1'b1 || cur_ch !== 2'd0) begin fails++; $display("FAIL rst_restart got busy=%b cur=%0d exp busy=1 cur=0", busy, cur_ch); end
    set_data(16'h0009, 16'h0050, 16'h0030, 16'h0044);
    tick();
    nd = 1'b1; tick(); nd = 1'b0;
    wait_valid(cyc);
    checks++; if (cyc !== 2 || res_ch !== 2'd0 || res_max !== 16'h0009)
      begin fails++; $display("FAIL rst_first got cyc=%0d ch=%0d max=%h exp cyc=2 ch=0 max=0009", cyc, res_ch, res_max); end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; nd = 1'b0; res_ready = 1'b0; win_len = '0; data_in = '0;
    test_reset();
    test_single();
    test_saturation_rr();
    test_backpressure();
    test_winlen0_sparse();
    test_enable_drop();
    test_rst_in_report();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
